multichan_downsampler: RTL
==========================

MULTICHAN_DOWNSAMPLER -- requirements
Module: multichan_downsampler

Interface
REQ-001 SHALL have parameter DATA_WIDTH_INP, default 16, bit width of one channel sample (signed).
REQ-002 SHALL have parameter NUM_CH, default 2, number of lanes sharing one input strobe (>=1).
REQ-003 SHALL have parameter MAX_R, default 16, largest programmable decimation ratio (>=2).
REQ-004 SHALL have parameter DEFAULT_R, default 4, ratio in force after reset (1..MAX_R).
REQ-005 SHALL have parameter FIFO_DEPTH, default 4, output frame buffer depth (power of two, >=2).
REQ-006 SHALL have port clk  input  1  single clock, all logic on rising edge.
REQ-007 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-008 SHALL have port clear  input  1  synchronous soft reset, same effect as reset_n.
REQ-009 SHALL have port cfg_ratio  input  RW=$clog2(MAX_R+1)  requested decimation ratio.
REQ-010 SHALL have port cfg_load  input  1  one-cycle pulse capturing cfg_ratio into the pending register.
REQ-011 SHALL have port inp_samp_data  input  NUM_CH*DATA_WIDTH_INP  lane k at bits [k*W +: W].
REQ-012 SHALL have port inp_samp_str  input  1  input frame strobe (no backpressure).
REQ-013 SHALL have port out_samp_data  output  NUM_CH*DATA_WIDTH_INP  head frame of buffer.
REQ-014 SHALL have port out_samp_valid  output  1  buffer non-empty.
REQ-015 SHALL have port out_samp_ready  input  1  consumer accepts head when valid.
REQ-016 SHALL have port overflow  output  1  sticky flag, kept frame dropped because buffer full.
REQ-017 SHALL have port active_ratio  output  RW  ratio currently applied.

Function
REQ-018 SHALL count input strobes in a phase counter 0..active_ratio-1; counter advances only on inp_samp_str.
REQ-019 SHALL keep the frame whose strobe arrives with counter == active_ratio-1, then wrap counter to 0.
REQ-020 SHALL treat cfg_ratio of 0 or >MAX_R as 1 (clamp at capture), ratio 1 keeping every frame.
REQ-021 SHALL hold a captured ratio as pending; pending becomes active on the strobe that wraps the counter, never mid-period.
REQ-022 SHALL apply a pending ratio immediately if no strobe has occurred since reset/clear (counter 0, idle flag set).
REQ-023 SHALL, on cfg_load coincident with a wrapping strobe, make the newly captured value active at that wrap.
REQ-024 SHALL write a kept frame into the buffer on the same rising edge; out_samp_valid rises the following cycle (no bypass).
REQ-025 SHALL present head frame on out_samp_data while valid, stable until the handshake valid&&ready.
REQ-026 SHALL accept a kept frame when buffer full only if a pop occurs the same cycle; otherwise drop it and set overflow.
REQ-027 SHALL support simultaneous push and pop at any occupancy with occupancy unchanged.
REQ-028 SHALL ignore out_samp_ready when out_samp_valid is low (no underflow).
REQ-029 SHALL keep overflow set until reset_n or clear.

Reset
REQ-030 SHALL on reset_n low or clear high: counter 0, pending and active ratio DEFAULT_R, buffer empty, out_samp_valid 0, out_samp_data 0, overflow 0.
REQ-031 SHALL give clear priority over inp_samp_str, cfg_load and pops in the same cycle.
REQ-032 SHALL discard buffered frames when reset/clear arrives mid-operation.

Structure
REQ-033 SHALL place ratio-width function, clamp function and DEFAULT constants in package downsampler_pkg.
REQ-034 SHALL implement the buffer as sub-module samp_fifo (synchronous, registered pointers, full/empty flags).

Verification
REQ-035 SHALL check: DEFAULT_R=4, 12 strobes data 1..12 -> output frames 4, 8, 12, overflow 0.
REQ-036 SHALL check: cfg_load ratio 3 after strobe 2 of a ratio-4 period -> keeps 4, then 7, 10.
REQ-037 SHALL check: cfg_ratio 0 loaded at idle -> every strobe kept, active_ratio 1.
REQ-038 SHALL check: ratio 1, ready low, 5 strobes, FIFO_DEPTH 4 -> frames 1..4 buffered, 5 dropped, overflow 1.
REQ-039 SHALL check: full buffer, kept frame with ready high same cycle -> no drop, occupancy stays 4.
REQ-040 SHALL check: clear asserted with 2 frames buffered and strobe same cycle -> valid 0 next cycle, counter 0, overflow 0.

Source files
------------

// File: rtl/downsampler_pkg.sv
// rtl/downsampler_pkg.sv - shared constants and ratio helpers for the multichannel downsampler
package downsampler_pkg;

    localparam int DEF_DATA_WIDTH = 16;
    localparam int DEF_NUM_CH     = 2;
    localparam int DEF_MAX_R      = 16;
    localparam int DEF_RATIO      = 4;
    localparam int DEF_FIFO_DEPTH = 4;

    function automatic int ratio_width(input int max_r);
        return $clog2(max_r + 1);
    endfunction

    // Out-of-range requests fall back to pass-through rather than stalling the phase counter.
    function automatic int clamp_ratio(input int raw, input int max_r);
        return (raw < 1 || raw > max_r) ? 1 : raw;
    endfunction

endpackage

// File: rtl/samp_fifo.sv
// rtl/samp_fifo.sv - synchronous frame buffer with registered pointers and full/empty flags
module samp_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             clear,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] head_data,
    output logic             full,
    output logic             empty
);

    localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign empty     = (wr_ptr == rd_ptr);
    assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop    = pop && !empty;
    // A pop in the same cycle frees the slot the push needs, even when full.
    assign do_push   = push && (!full || do_pop);
    assign head_data = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PTR_ONE;
            if (do_pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr[AW-1:0]] <= push_data;
    end

endmodule

// File: rtl/multichan_downsampler.sv
// rtl/multichan_downsampler.sv - keeps one of every N input frames across all lanes into a frame buffer
module multichan_downsampler
    import downsampler_pkg::*;
#(
    parameter int DATA_WIDTH_INP = DEF_DATA_WIDTH,
    parameter int NUM_CH         = DEF_NUM_CH,
    parameter int MAX_R          = DEF_MAX_R,
    parameter int DEFAULT_R      = DEF_RATIO,
    parameter int FIFO_DEPTH     = DEF_FIFO_DEPTH,
    localparam int RW            = ratio_width(MAX_R),
    localparam int FW            = NUM_CH * DATA_WIDTH_INP
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          clear,
    input  logic [RW-1:0] cfg_ratio,
    input  logic          cfg_load,
    input  logic [FW-1:0] inp_samp_data,
    input  logic          inp_samp_str,
    output logic [FW-1:0] out_samp_data,
    output logic          out_samp_valid,
    input  logic          out_samp_ready,
    output logic          overflow,
    output logic [RW-1:0] active_ratio
);

    localparam logic [RW-1:0] ONE       = RW'(1);
    localparam logic [RW-1:0] RESET_R   = RW'(DEFAULT_R);

    logic [RW-1:0] phase;
    logic [RW-1:0] pending;
    logic [RW-1:0] load_val;
    logic [RW-1:0] eff_ratio;
    logic          idle;
    logic          wrap;
    logic          pop;
    logic          full;
    logic          empty;

    assign load_val  = cfg_load ? RW'(clamp_ratio(int'(cfg_ratio), MAX_R)) : pending;
    // Before the first strobe nothing is mid-period, so a fresh load governs immediately.
    assign eff_ratio = (idle && cfg_load) ? load_val : active_ratio;
    assign wrap      = inp_samp_str && (phase == eff_ratio - ONE);

    assign out_samp_valid = !empty;
    assign pop            = out_samp_valid && out_samp_ready;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase        <= '0;
            pending      <= RESET_R;
            active_ratio <= RESET_R;
            idle         <= 1'b1;
            overflow     <= 1'b0;
        end else if (clear) begin
            phase        <= '0;
            pending      <= RESET_R;
            active_ratio <= RESET_R;
            idle         <= 1'b1;
            overflow     <= 1'b0;
        end else begin
            pending <= load_val;
            if (inp_samp_str) begin
                idle <= 1'b0;
                if (wrap) begin
                    phase        <= '0;
                    active_ratio <= load_val;
                end else begin
                    phase <= phase + ONE;
                end
            end else if (idle && cfg_load) begin
                active_ratio <= load_val;
            end
            if (wrap && full && !pop) overflow <= 1'b1;
        end
    end

    samp_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (clear),
        .push      (wrap),
        .push_data (inp_samp_data),
        .pop       (pop),
        .head_data (out_samp_data),
        .full      (full),
        .empty     (empty)
    );

endmodule
